ui_debounce_capture: RTL
========================

Name: ui_debounce_capture

Overview:
Input-conditioning stage that sits directly upstream of the top-level user logic on the dedicated input pins (ui_in). It synchronises the raw asynchronous switch/button byte, debounces each bit independently, and presents a clean stable byte. A change event carries a per-bit change mask and uses a valid/ready handshake, so downstream logic sees each debounced transition exactly once.

Parameters:
WIDTH, 8, number of input bits conditioned.
SYNC_STAGES, 2, flops in the per-bit synchroniser chain; minimum 2.
DEBOUNCE_CYCLES, 16, number of consecutive synchronised samples that must differ from dout before a bit flips; minimum 1.
CNT_W, max(1, clog2(DEBOUNCE_CYCLES)), derived width of each per-bit counter; not overridden.

Ports:
clk  input  1  system clock, the single clock domain.
rst  input  1  synchronous active-high reset; the top level drives it as ~rst_n.
din  input  WIDTH  raw asynchronous inputs (ui_in).
dout  output  WIDTH  debounced stable value.
evt_valid  output  1  change event pending.
evt_ready  input  1  downstream accepts the event when high together with evt_valid.
evt_mask  output  WIDTH  bits that flipped since the last accepted event.
evt_overflow  output  1  more than one flip cycle was merged into the pending event.

Behaviour:
- Reset: applied synchronously on a clk edge with rst=1. Clears all synchroniser flops, counters, dout, evt_valid, evt_mask and evt_overflow to 0. Reset overrides all other activity, including mid-debounce and pending events.
- Synchroniser: per bit, a SYNC_STAGES-deep chain. s[i] is the last stage and is the only signal the debounce logic reads.
- Debounce, per bit i, on every edge:
  - s[i]==dout[i]: cnt[i] is cleared to 0.
  - s[i]!=dout[i] and cnt[i]==DEBOUNCE_CYCLES-1: dout[i] takes s[i] and cnt[i] is cleared.
  - otherwise: cnt[i] increments.
- Latency: if din changes before edge 1 and stays stable, dout updates on edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Glitch rejection: a pulse on s[i] that lasts fewer than DEBOUNCE_CYCLES edges never reaches dout and leaves cnt[i]=0 once it ends.
- Bits are independent; several bits may flip on the same edge.
- Flip vector f = the bits of dout that change on this edge. The event register updates on each edge, in priority order:
  1. f!=0 and (!evt_valid or evt_ready): evt_valid<=1, evt_mask<=f, evt_overflow<=0.
  2. f!=0 and evt_valid and !evt_ready: evt_mask<=evt_mask|f, evt_overflow<=1.
  3. f==0 and evt_valid and evt_ready: evt_valid<=0, evt_mask<=0, evt_overflow<=0.
  4. otherwise: hold.
- A handshake that coincides with a new flip accepts the old event and loads the new one with no idle cycle between them.
- evt_mask and evt_overflow are stable while evt_valid=1 and evt_ready=0, except for OR-accumulation under rule 2.
- evt_ready is ignored while evt_valid=0.
- evt_valid depends only on registered state: there is no combinational path from evt_ready to any output.
- A bit that flips and flips back while an event is pending keeps its mask bit set. dout always shows the current debounced value.

Test Plan:
- Reset with din=8'hFF held → dout=0, evt_valid=0, evt_mask=0, evt_overflow=0 during reset. After release, with DEBOUNCE_CYCLES=4 and SYNC_STAGES=2, dout=8'hFF on the 6th edge and evt_valid=1, evt_mask=8'hFF on the same edge.
- DEBOUNCE_CYCLES=4, evt_ready=1: din[3] 0→1 before edge 1 → dout[3]=1 after edge 6, evt_valid high for exactly one cycle with evt_mask=8'h08.
- din[0] pulsed high for 3 cycles with DEBOUNCE_CYCLES=4 → dout, evt_valid and evt_mask never change, and cnt[0] returns to 0.
- evt_ready=0: din[1] flips, then din[5] flips 10 cycles later → evt_mask=8'h02 then 8'h22, evt_overflow=1. Raising evt_ready for one cycle → evt_valid=0, mask=0, overflow=0.
- evt_ready asserted on the same edge that din[7]'s flip completes while mask=8'h02 is pending → next cycle evt_valid=1, evt_mask=8'h80, evt_overflow=0.
- rst asserted mid-debounce (cnt=2) and with an event pending → all outputs 0 next edge. After release, a stable din=8'h01 reproduces the full 6-edge latency from the post-reset edge.

Source files
------------

// File: rtl/ui_debounce_capture.sv
// Input conditioning for raw switch/button pins: per-bit synchroniser and debouncer,
// plus a valid/ready change event that reports each debounced flip exactly once.
module ui_debounce_capture #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_mask,
  output logic             evt_overflow
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] w_dout;
  logic [WIDTH-1:0] w_flip;
  logic             w_any_flip;

  logic             r_evt_valid;
  logic [WIDTH-1:0] r_evt_mask;
  logic             r_evt_overflow;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [SYNC_STAGES-1:0] r_sync;
      logic [CNT_W-1:0]       r_cnt;
      logic                   r_dout;
      logic                   w_s;
      logic                   w_hit;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], din[gi]};
        end
      end

      assign w_s = r_sync[SYNC_STAGES-1];

      // The sample that completes the run of disagreeing samples flips the bit.
      assign w_hit = (w_s != r_dout) && (r_cnt == CNT_LAST);

      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt  <= '0;
          r_dout <= 1'b0;
        end else if (w_s == r_dout) begin
          r_cnt <= '0;
        end else if (w_hit) begin
          r_dout <= w_s;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign w_flip[gi] = w_hit;
      assign w_dout[gi] = r_dout;
    end
  endgenerate

  assign w_any_flip = |w_flip;

  // A handshake coinciding with a new flip retires the old event and loads the new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt_valid    <= 1'b0;
      r_evt_mask     <= '0;
      r_evt_overflow <= 1'b0;
    end else if (w_any_flip && (!r_evt_valid || evt_ready)) begin
      r_evt_valid    <= 1'b1;
      r_evt_mask     <= w_flip;
      r_evt_overflow <= 1'b0;
    end else if (w_any_flip) begin
      r_evt_mask     <= r_evt_mask | w_flip;
      r_evt_overflow <= 1'b1;
    end else if (r_evt_valid && evt_ready) begin
      r_evt_valid    <= 1'b0;
      r_evt_mask     <= '0;
      r_evt_overflow <= 1'b0;
    end
  end

  assign dout         = w_dout;
  assign evt_valid    = r_evt_valid;
  assign evt_mask     = r_evt_mask;
  assign evt_overflow = r_evt_overflow;

endmodule
